// File: rtl/sccb_init_seq.sv
// SCCB register-table init sequencer: walks a ROM of {sub_addr, data}
// words, issues writes to an SCCB master, handles delay and end entries.
module sccb_init_seq #(
    parameter logic [7:0] DEV_ID     = 8'h42,
    parameter int         CLK_DIV    = 250,
    parameter int         DELAY_UNIT = 50_000,
    parameter int         TIMEOUT    = 2_000_000,
    parameter int         ROM_AW     = 8
) (
    input  logic              XCLK,
    input  logic              RST,
    input  logic              go,
    output logic              busy,
    output logic              init_done,
    output logic              error,
    output logic [ROM_AW-1:0] wr_count,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_start,
    output logic              sccb_rw,
    output logic [7:0]        sccb_ip_addr,
    output logic [7:0]        sccb_sub_addr,
    output logic [7:0]        sccb_data_in,
    input  logic              sccb_done,
    output logic              SCCB_CLK,
    output logic              SCCB_MID_PULSE
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int TW = $clog2(TIMEOUT);
    localparam int DW = $clog2(255 * DELAY_UNIT + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    // one cycle ahead of the mid point, so the registered strobe lands on it
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_DIV / 2 - 2);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RELEASE,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic [DW-1:0] dcnt;

    assign sccb_rw      = 1'b0;
    assign sccb_ip_addr = DEV_ID;

    // Free-running bit clock divider with a mid-low-phase strobe
    always_ff @(posedge XCLK) begin
        if (RST) begin
            cnt            <= '0;
            SCCB_CLK       <= 1'b0;
            SCCB_MID_PULSE <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt      <= '0;
                SCCB_CLK <= ~SCCB_CLK;
            end else begin
                cnt <= cnt + CW'(1);
            end
            SCCB_MID_PULSE <= (cnt == CNT_PRE) && !SCCB_CLK;
        end
    end

    // Table-walk FSM with registered status and SCCB request outputs
    always_ff @(posedge XCLK) begin
        if (RST) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            init_done     <= 1'b0;
            error         <= 1'b0;
            wr_count      <= '0;
            rom_addr      <= '0;
            sccb_start    <= 1'b0;
            sccb_sub_addr <= '0;
            sccb_data_in  <= '0;
            tcnt          <= '0;
            dcnt          <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (go) begin
                        rom_addr  <= '0;
                        wr_count  <= '0;
                        tcnt      <= '0;
                        busy      <= 1'b1;
                        init_done <= 1'b0;
                        error     <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (rom_data[15:8] == 8'hFF) begin
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                        state     <= S_DONE;
                    end else if (rom_data[15:8] == 8'hFE) begin
                        dcnt  <= DW'(32'(rom_data[7:0]) * 32'(DELAY_UNIT));
                        state <= S_DELAY;
                    end else begin
                        sccb_sub_addr <= rom_data[15:8];
                        sccb_data_in  <= rom_data[7:0];
                        sccb_start    <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tcnt  <= '0;
                    state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (sccb_done) begin
                        sccb_start <= 1'b0;
                        state      <= S_RELEASE;
                    end else if (tcnt == TO_LAST) begin
                        sccb_start <= 1'b0;
                        busy       <= 1'b0;
                        error      <= 1'b1;
                        state      <= S_ERROR;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_RELEASE: begin
                    if (!sccb_done) begin
                        wr_count <= wr_count + ROM_AW'(1);
                        rom_addr <= rom_addr + ROM_AW'(1);
                        state    <= S_FETCH;
                    end
                end
                S_DELAY: begin
                    // a load of N stays N cycles; a load of 0 still takes one
                    if (dcnt <= DW'(1)) begin
                        dcnt     <= '0;
                        rom_addr <= rom_addr + ROM_AW'(1);
                        state    <= S_FETCH;
                    end else begin
                        dcnt <= dcnt - DW'(1);
                    end
                end
                default: begin
                    busy       <= 1'b0;
                    sccb_start <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: table vectors, random tables against a
// table-walk model, and hand sequences for clock, reset and go corners.
module tb_sccb_init_seq;

    localparam logic [7:0] DEV = 8'h42;

    logic        XCLK;
    logic        RST;
    logic        go;
    logic        busy;
    logic        init_done;
    logic        error;
    logic [7:0]  wr_count;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_start;
    logic        sccb_rw;
    logic [7:0]  sccb_ip_addr;
    logic [7:0]  sccb_sub_addr;
    logic [7:0]  sccb_data_in;
    logic        sccb_done;
    logic        SCCB_CLK;
    logic        SCCB_MID_PULSE;

    sccb_init_seq #(
        .DEV_ID    (DEV),
        .CLK_DIV   (4),
        .DELAY_UNIT(10),
        .TIMEOUT   (100),
        .ROM_AW    (8)
    ) dut (
        .XCLK          (XCLK),
        .RST           (RST),
        .go            (go),
        .busy          (busy),
        .init_done     (init_done),
        .error         (error),
        .wr_count      (wr_count),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .sccb_start    (sccb_start),
        .sccb_rw       (sccb_rw),
        .sccb_ip_addr  (sccb_ip_addr),
        .sccb_sub_addr (sccb_sub_addr),
        .sccb_data_in  (sccb_data_in),
        .sccb_done     (sccb_done),
        .SCCB_CLK      (SCCB_CLK),
        .SCCB_MID_PULSE(SCCB_MID_PULSE)
    );

    initial XCLK = 1'b0;
    always #5 XCLK = ~XCLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // synchronous ROM, one cycle of latency
    logic [15:0] rom_mem [256];
    always @(posedge XCLK) rom_data <= rom_mem[rom_addr];

    // behavioural SCCB master
    int          hang_after;
    int          lat_min;
    int          lat_max;
    logic        m_done;
    logic        m_active;
    int          m_cnt;
    logic        stray_done;
    logic [15:0] log_q [$];

    assign sccb_done = m_done | stray_done;

    always @(posedge XCLK) begin
        if (RST) begin
            m_done   <= 1'b0;
            m_active <= 1'b0;
            m_cnt    <= 0;
        end else if (m_active) begin
            if (m_cnt == 0) begin
                m_done   <= 1'b1;
                m_active <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (m_done) begin
            if (!sccb_start && SCCB_MID_PULSE) begin
                m_done <= 1'b0;
                chk("stable", {sccb_sub_addr, sccb_data_in}, log_q[$]);
            end
        end else if (sccb_start &&
                     (hang_after < 0 || log_q.size() < hang_after)) begin
            m_active <= 1'b1;
            m_cnt    <= int'($urandom_range(lat_max, lat_min));
            log_q.push_back({sccb_sub_addr, sccb_data_in});
        end
    end

    // reference model: walk the table by its rules
    logic [15:0] exp_q [$];
    int          m_wr;
    int          m_addr;
    logic        m_ok;

    task automatic model_walk(input int hang);
        logic [15:0] w;
        exp_q.delete();
        m_ok = 1'b0;
        m_addr = 0;
        for (int i = 0; i < 256; i++) begin
            w = rom_mem[i];
            if (w[15:8] == 8'hFF) begin
                m_ok = 1'b1;
                m_addr = i;
                break;
            end
            if (w[15:8] != 8'hFE) begin
                if (hang >= 0 && exp_q.size() >= hang) begin
                    m_addr = i;
                    break;
                end
                exp_q.push_back(w);
            end
        end
        m_wr = exp_q.size();
    endtask

    task automatic chk_log();
        chk("log_len", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk("log_word", log_q[i], exp_q[i]);
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", busy, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_error", error, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_start", sccb_start, 0);
        chk("rst_rw", sccb_rw, 0);
        chk("rst_sub", sccb_sub_addr, 0);
        chk("rst_data", sccb_data_in, 0);
        chk("rst_sclk", SCCB_CLK, 0);
        chk("rst_mid", SCCB_MID_PULSE, 0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFF00;
    endtask

    task automatic pulse_go();
        @(negedge XCLK);
        go = 1'b1;
        @(negedge XCLK);
        go = 1'b0;
    endtask

    task automatic wait_idle(output int t);
        t = 0;
        while (busy && t < 20000) begin
            @(negedge XCLK);
            t++;
        end
        chk("idle_bound", busy, 0);
    endtask

    typedef struct {
        logic [0:5][15:0] w;
        int               hang;
        int               exp_wr;
        int               exp_addr;
        logic             exp_done;
        int               exp_lat;
        int               exp_tail;
    } vec_t;

    vec_t vt [7];

    task automatic run_vec(input vec_t v);
        int n;
        int t;
        clear_rom();
        for (int i = 0; i < 6; i++) rom_mem[i] = v.w[i];
        hang_after = v.hang;
        log_q.delete();
        pulse_go();
        if (v.exp_lat >= 0) begin
            n = 0;
            while (!sccb_start && n < 2000) begin
                @(negedge XCLK);
                n++;
            end
            chk("start_latency", n, v.exp_lat);
        end
        wait_idle(t);
        if (v.exp_tail >= 0) chk("end_latency", t, v.exp_tail);
        chk("wr_count", wr_count, v.exp_wr);
        chk("rom_addr", rom_addr, v.exp_addr);
        chk("init_done", init_done, v.exp_done);
        chk("error", error, !v.exp_done);
        chk("end_start", sccb_start, 0);
        chk("ip_addr", sccb_ip_addr, DEV);
        chk("rw", sccb_rw, 0);
        model_walk(v.hang);
        chk_log();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        int ne;
        RST = 1'b1;
        go = 1'b0;
        stray_done = 1'b0;
        hang_after = -1;
        lat_min = 0;
        lat_max = 8;
        clear_rom();

        vt[0] = '{w: {16'h1280, 16'h1101, 16'hFF00, 16'hFF00, 16'hFF00,
                      16'hFF00}, hang: -1, exp_wr: 2, exp_addr: 2,
                  exp_done: 1'b1, exp_lat: 2, exp_tail: -1};
        vt[1] = '{w: {16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00,
                      16'hFF00}, hang: -1, exp_wr: 0, exp_addr: 0,
                  exp_done: 1'b1, exp_lat: -1, exp_tail: 2};
        vt[2] = '{w: {16'hFE00, 16'h3A04, 16'hFF00, 16'hFF00, 16'hFF00,
                      16'hFF00}, hang: -1, exp_wr: 1, exp_addr: 2,
                  exp_done: 1'b1, exp_lat: 5, exp_tail: -1};
        vt[3] = '{w: {16'hFE03, 16'h3A04, 16'hFF00, 16'hFF00, 16'hFF00,
                      16'hFF00}, hang: -1, exp_wr: 1, exp_addr: 2,
                  exp_done: 1'b1, exp_lat: 34, exp_tail: -1};
        vt[4] = '{w: {16'h1234, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00,
                      16'hFF00}, hang: 0, exp_wr: 0, exp_addr: 0,
                  exp_done: 1'b0, exp_lat: 2, exp_tail: 101};
        vt[5] = '{w: {16'h1234, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00,
                      16'hFF00}, hang: -1, exp_wr: 1, exp_addr: 1,
                  exp_done: 1'b1, exp_lat: 2, exp_tail: -1};
        vt[6] = '{w: {16'hAA55, 16'h0102, 16'hFF00, 16'hFF00, 16'hFF00,
                      16'hFF00}, hang: 1, exp_wr: 1, exp_addr: 1,
                  exp_done: 1'b0, exp_lat: 2, exp_tail: -1};

        // reset values, then the free-running divider with no go
        repeat (3) @(posedge XCLK);
        @(negedge XCLK);
        chk_reset_vals();
        @(posedge XCLK);
        #1 RST = 1'b0;
        for (int j = 0; j < 24; j++) begin
            @(negedge XCLK);
            chk("sclk_phase", SCCB_CLK, (j / 4) % 2);
            chk("mid_pulse", SCCB_MID_PULSE, (j % 8) == 1);
        end

        // table-driven vectors
        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // random tables against the model
        for (int r = 0; r < 10; r++) begin
            clear_rom();
            n = $urandom_range(7, 1);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(3, 0) == 0)
                    rom_mem[i] = {8'hFE, 8'($urandom_range(3, 0))};
                else
                    rom_mem[i] = {8'($urandom_range(253, 0)),
                                  8'($urandom)};
            end
            hang_after = ($urandom_range(3, 0) == 0) ?
                         int'($urandom_range(3, 0)) : -1;
            lat_min = 0;
            lat_max = $urandom_range(15, 0);
            log_q.delete();
            pulse_go();
            wait_idle(t);
            model_walk(hang_after);
            chk("rnd_wr_count", wr_count, m_wr);
            chk("rnd_rom_addr", rom_addr, m_addr);
            chk("rnd_init_done", init_done, m_ok);
            chk("rnd_error", error, !m_ok);
            chk("rnd_start", sccb_start, 0);
            chk_log();
        end

        // go while busy, stray done during a delay
        clear_rom();
        rom_mem[0] = 16'hFE05;
        rom_mem[1] = 16'h1280;
        hang_after = -1;
        lat_min = 5;
        lat_max = 10;
        log_q.delete();
        pulse_go();
        repeat (5) @(negedge XCLK);
        stray_done = 1'b1;
        repeat (3) @(negedge XCLK);
        stray_done = 1'b0;
        chk("dly_rom_addr", rom_addr, 0);
        chk("dly_busy", busy, 1);
        ne = 0;
        while (!sccb_start && ne < 2000) begin
            @(negedge XCLK);
            ne++;
        end
        chk("gb_start_seen", sccb_start, 1);
        go = 1'b1;
        @(negedge XCLK);
        go = 1'b0;
        chk("gb_rom_addr", rom_addr, 1);
        chk("gb_start_held", sccb_start, 1);
        wait_idle(t);
        chk("gb_wr_count", wr_count, 1);
        chk("gb_end_addr", rom_addr, 2);
        chk("gb_done", init_done, 1);
        chk("gb_log_len", log_q.size(), 1);
        chk("gb_log_word", log_q[0], 16'h1280);

        // reset in WAIT_DONE of entry 1
        clear_rom();
        rom_mem[0] = 16'h1280;
        rom_mem[1] = 16'h1101;
        lat_min = 40;
        lat_max = 40;
        log_q.delete();
        pulse_go();
        ne = 0;
        while (!(wr_count == 8'd1 && sccb_start) && ne < 5000) begin
            @(negedge XCLK);
            ne++;
        end
        chk("mid_rst_reach", ne < 5000, 1);
        repeat (2) @(negedge XCLK);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_start", sccb_start, 1);
        RST = 1'b1;
        @(negedge XCLK);
        chk_reset_vals();
        RST = 1'b0;
        repeat (20) @(negedge XCLK);
        chk("no_resume_busy", busy, 0);
        chk("no_resume_start", sccb_start, 0);
        chk("no_resume_wr", wr_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
